// File: rtl/nandy_pkg.sv
// Shared constants for the Nandy 8-bit CPU control path: instruction field
// positions, ALU opcodes and idle levels of the active-low strobe bus.
package nandy_pkg;

    localparam int unsigned BIT_RS0 = 0;
    localparam int unsigned BIT_CLI = 1;
    localparam int unsigned BIT_LJR = 2;
    localparam int unsigned BIT_WR  = 3;
    localparam int unsigned BIT_S   = 4;
    localparam int unsigned BIT_Y   = 5;
    localparam int unsigned BIT_G6  = 6;
    localparam int unsigned BIT_G7  = 7;

    localparam logic [3:0] ALU_PASS    = 4'h0;
    localparam logic [3:0] ALU_DEFAULT = 4'h8;
    localparam logic [7:0] NSIG_IDLE   = 8'hFF;

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all zeros when disabled.
// Latency 0 (combinational); no handshake.
module onehot_dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] oneHot
);

    always_comb begin
        oneHot = '0;
        if (en) begin
            oneHot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_decoder.sv
// Nandy CPU instruction decoder: inst/cycle/carry -> datapath and bus strobes.
// Latency 0 (combinational); no backpressure, rst forces every output idle.
module control_decoder
    import nandy_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst,
    input  logic       cycle,
    input  logic       carry,
    output logic       M,
    output logic       S,
    output logic       J,
    output logic       LJ,
    output logic       nCLI,
    output logic       nLJR,
    output logic       MW,
    output logic       MC,
    output logic       RD,
    output logic       WR,
    output logic       Y,
    output logic [1:0] RS,
    output logic       WA,
    output logic       nISP,
    output logic       WC,
    output logic [3:0] ALU,
    output logic [7:0] nSIG
);

    // Clock is part of the uniform block interface only; decode never samples it.
    logic unusedClk;
    assign unusedClk = clk;

    logic i7, i6, i5, i4, i3, i2, i1;
    assign i7 = inst[BIT_G7];
    assign i6 = inst[BIT_G6];
    assign i5 = inst[BIT_Y];
    assign i4 = inst[BIT_S];
    assign i3 = inst[BIT_WR];
    assign i2 = inst[BIT_LJR];
    assign i1 = inst[BIT_CLI];

    logic zGroup, spGroup, aluWrite;
    assign zGroup   = ~i7 & ~i6 & ~i5;
    assign spGroup  = ~i7 & ~i6 & i5;
    assign aluWrite = (i6 & ~i7) | (cycle & i6 & ~i5);

    logic memDec, jmpDec, longDec, rdDec, wrDec, waDec, wcDec, sigEn;
    logic [3:0] aluDec;
    logic [7:0] sigOneHot;

    assign memDec  = i7 & ~i6 & cycle;
    // i4 turns the jump into "jump if carry clear".
    assign jmpDec  = i7 & i6 & i5 & cycle & ~(carry & i4);
    assign longDec = zGroup & i4 & ~i3;
    assign rdDec   = zGroup & ~i4 & i2;
    assign wrDec   = zGroup & ~i4 & i3;
    assign waDec   = (memDec & ~i5) | (aluWrite & ~(i4 & ~i3));
    assign wcDec   = (aluWrite | spGroup) & i4;
    assign aluDec  = i6 ? inst[3:0] : (i7 ? ALU_PASS : ALU_DEFAULT);
    assign sigEn   = zGroup & i4 & i3;

    onehot_dec3to8 u_sigDec (
        .en     (sigEn),
        .sel    (inst[2:0]),
        .oneHot (sigOneHot)
    );

    assign M    = rst ? 1'b0 : memDec;
    assign S    = rst ? 1'b0 : i4;
    assign Y    = rst ? 1'b0 : i5;
    assign RS   = rst ? 2'b00 : inst[BIT_RS0 +: 2];
    assign J    = rst ? 1'b0 : jmpDec;
    assign LJ   = rst ? 1'b0 : longDec;
    assign nCLI = rst ? 1'b1 : ~(longDec & i1);
    assign nLJR = rst ? 1'b1 : ~(longDec & i2);
    assign MW   = rst ? 1'b0 : (memDec & i5);
    assign MC   = rst ? 1'b0 : (i7 & ~cycle);
    assign RD   = rst ? 1'b0 : rdDec;
    assign WR   = rst ? 1'b0 : wrDec;
    assign nISP = rst ? 1'b1 : ~spGroup;
    assign WA   = rst ? 1'b0 : waDec;
    assign WC   = rst ? 1'b0 : wcDec;
    assign ALU  = rst ? ALU_PASS : aluDec;
    assign nSIG = rst ? NSIG_IDLE : ~sigOneHot;

endmodule

// File: tb/tb_control_decoder.sv
// Bench for control_decoder: directed decode cases, reset override, an
// exhaustive input sweep and random stimulus against an arithmetic model.
module tb_control_decoder;

    typedef struct packed {
        logic       m, s, j, lj, nCli, nLjr, mw, mc, rd, wr, y;
        logic [1:0] rs;
        logic       wa, nIsp, wc;
        logic [3:0] alu;
        logic [7:0] nSig;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] inst = 8'h00;
    logic       cycle = 1'b0;
    logic       carry = 1'b0;

    logic       M, S, J, LJ, nCLI, nLJR, MW, MC, RD, WR, Y, WA, nISP, WC;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] nSIG;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_decoder dut (
        .clk(clk), .rst(rst), .inst(inst), .cycle(cycle), .carry(carry),
        .M(M), .S(S), .J(J), .LJ(LJ), .nCLI(nCLI), .nLJR(nLJR), .MW(MW),
        .MC(MC), .RD(RD), .WR(WR), .Y(Y), .RS(RS), .WA(WA), .nISP(nISP),
        .WC(WC), .ALU(ALU), .nSIG(nSIG)
    );

    dec_t got;
    assign got = {M, S, J, LJ, nCLI, nLJR, MW, MC, RD, WR, Y, RS, WA, nISP, WC, ALU, nSIG};

    task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (inst=0x%02h cycle=%0b carry=%0b rst=%0b)",
                     tag, actual, expected, inst, cycle, carry, rst);
        end
    endtask

    function automatic dec_t idleOut();
        dec_t r;
        r = '0;
        r.nCli = 1'b1;
        r.nLjr = 1'b1;
        r.nIsp = 1'b1;
        r.nSig = 8'hFF;
        return r;
    endfunction

    // Model works on the opcode group (top three bits) as a number.
    function automatic dec_t model(input int unsigned op, input bit cyc, input bit cy, input bit rs);
        dec_t r;
        int unsigned grp;
        bit b4, b3, b2, b1, z, a;
        if (rs) return idleOut();
        grp = op / 32;
        b4 = ((op / 16) % 2) == 1;
        b3 = ((op / 8) % 2) == 1;
        b2 = ((op / 4) % 2) == 1;
        b1 = ((op / 2) % 2) == 1;
        z  = (grp == 0);
        a  = (grp == 2 || grp == 3) || (cyc && (grp == 2 || grp == 6));
        r = '0;
        r.m    = (grp == 4 || grp == 5) && cyc;
        r.s    = b4;
        r.y    = (grp % 2) == 1;
        r.rs   = 2'(op % 4);
        r.j    = (grp == 7) && cyc && !(cy && b4);
        r.lj   = z && b4 && !b3;
        r.nCli = !(r.lj && b1);
        r.nLjr = !(r.lj && b2);
        r.mw   = (grp == 5) && cyc;
        r.mc   = (grp >= 4) && !cyc;
        r.rd   = z && !b4 && b2;
        r.wr   = z && !b4 && b3;
        r.nIsp = (grp != 1);
        r.wa   = (grp == 4 && cyc) || (a && !(b4 && !b3));
        r.wc   = (a || grp == 1) && b4;
        if (grp == 2 || grp == 3 || grp == 6 || grp == 7) r.alu = 4'(op % 16);
        else r.alu = (grp >= 4) ? 4'd0 : 4'd8;
        r.nSig = (z && b4 && b3) ? (8'hFF ^ 8'(1 << (op % 8))) : 8'hFF;
        return r;
    endfunction

    task automatic apply(input logic [7:0] i, input logic c, input logic cy);
        @(posedge clk);
        inst = i;
        cycle = c;
        carry = cy;
        #2;
    endtask

    initial begin
        dec_t exp;

        // Reset with a live jump on the inputs: everything idle, then decode without a clock edge.
        inst = 8'hF0; cycle = 1'b1; carry = 1'b0; rst = 1'b1;
        #2;
        checkEq("reset_idle", 32'(got), 32'(idleOut()));
        #1 rst = 1'b0;
        #1;
        checkEq("reset_release_J", 32'(J), 32'd1);
        checkEq("reset_release_all", 32'(got), 32'(model(32'hF0, 1'b1, 1'b0, 1'b0)));

        apply(8'h16, 1'b0, 1'b0);
        checkEq("x16_LJ", 32'(LJ), 32'd1);
        checkEq("x16_nCLI", 32'(nCLI), 32'd0);
        checkEq("x16_nLJR", 32'(nLJR), 32'd0);
        checkEq("x16_ALU", 32'(ALU), 32'd8);
        checkEq("x16_RS", 32'(RS), 32'd2);
        checkEq("x16_nSIG", 32'(nSIG), 32'hFF);
        checkEq("x16_misc", 32'({S, WA, WC, nISP, RD}), 32'b10010);

        apply(8'h1D, 1'b0, 1'b0);
        checkEq("x1D_nSIG", 32'(nSIG), 32'hDF);
        checkEq("x1D_LJ_RD_WR", 32'({LJ, RD, WR}), 32'd0);
        for (int k = 0; k < 8; k++) begin
            apply(8'h18 + 8'(k), 1'b0, 1'b0);
            checkEq($sformatf("sig_onehot_%0d", k), 32'($countones(~nSIG)), 32'd1);
            checkEq($sformatf("sig_bit_%0d", k), 32'(nSIG[k]), 32'd0);
        end

        apply(8'hE0, 1'b1, 1'b1);
        checkEq("xE0_J_uncond", 32'(J), 32'd1);
        apply(8'hF0, 1'b1, 1'b1);
        checkEq("xF0_J_carry_set", 32'(J), 32'd0);
        checkEq("xF0_ALU_WA_MC", 32'({ALU, WA, MC}), 32'd0);
        apply(8'hF0, 1'b1, 1'b0);
        checkEq("xF0_J_carry_clr", 32'(J), 32'd1);
        apply(8'hF0, 1'b0, 1'b0);
        checkEq("xF0_ph0_J_MC", 32'({J, MC}), 32'b01);

        apply(8'hA0, 1'b1, 1'b0);
        checkEq("xA0_ph1", 32'({M, MW, WA, Y}), 32'b1101);
        apply(8'hA0, 1'b0, 1'b0);
        checkEq("xA0_ph0", 32'({M, MC}), 32'b01);
        apply(8'h80, 1'b1, 1'b0);
        checkEq("x80_ph1", 32'({M, MW, WA}), 32'b101);
        checkEq("x80_ALU", 32'(ALU), 32'd0);

        apply(8'h47, 1'b0, 1'b0);
        checkEq("x47_WA_WC", 32'({WA, WC}), 32'b10);
        checkEq("x47_ALU_RS", 32'({ALU, RS}), {26'd0, 4'd7, 2'd3});
        apply(8'h57, 1'b0, 1'b0);
        checkEq("x57_WA_WC", 32'({WA, WC}), 32'b01);
        apply(8'h0C, 1'b0, 1'b0);
        checkEq("x0C_RD_WR_nISP", 32'({RD, WR, nISP}), 32'b111);
        apply(8'h30, 1'b0, 1'b0);
        checkEq("x30_nISP_WC", 32'({nISP, WC}), 32'b01);

        // Exhaustive sweep over inst x cycle x carry.
        for (int n = 0; n < 1024; n++) begin
            inst  = 8'(n % 256);
            cycle = ((n / 256) % 2) == 1;
            carry = (n / 512) == 1;
            #1;
            exp = model(n % 256, cycle, carry, 1'b0);
            if (got !== exp) checkEq($sformatf("sweep_%0d", n), 32'(got), 32'(exp));
            else checks++;
        end

        // Random stimulus including asynchronous reset pulses between edges.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            inst  = 8'($urandom_range(255));
            cycle = 1'($urandom_range(1));
            carry = 1'($urandom_range(1));
            rst   = ($urandom_range(7) == 0);
            #1;
            exp = model(int'(inst), cycle, carry, rst);
            checkEq("random", 32'(got), 32'(exp));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
